// File: rtl/wb_memory_responder_pkg.sv
// Shared types and constants for the Wishbone memory responder.
package wb_memory_responder_pkg;

  // Cycle-tag encodings used by the Theia core I/O unit (aDefinitions.v).
  localparam logic [1:0] WB_SIMPLE_READ_CYCLE  = 2'd0;
  localparam logic [1:0] WB_SIMPLE_WRITE_CYCLE = 2'd1;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_ADR_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  // A cycle tag announces a write when it carries the simple-write encoding.
  function automatic logic tag_is_write(input logic [1:0] tgc);
    return tgc == WB_SIMPLE_WRITE_CYCLE;
  endfunction

endpackage

// File: rtl/wb_memory_responder_if.sv
// Wishbone classic bus between the core I/O master and the memory responder.
interface wb_memory_responder_if;
  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic [31:0] ADR_I;
  logic [31:0] DAT_I;
  logic [1:0]  TGC_I;
  logic [31:0] DAT_O;
  logic        ACK_O;
  logic        GNT_O;
  logic        oTagMismatch;

  modport slave (
    input  CYC_I, STB_I, WE_I, ADR_I, DAT_I, TGC_I,
    output DAT_O, ACK_O, GNT_O, oTagMismatch
  );

  modport master (
    output CYC_I, STB_I, WE_I, ADR_I, DAT_I, TGC_I,
    input  DAT_O, ACK_O, GNT_O, oTagMismatch
  );
endinterface

// File: rtl/wb_responder_ram.sv
// Single-port synchronous RAM with registered read; swappable for a vendor macro.
module wb_responder_ram #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1 << ADDR_WIDTH)-1];
  logic [31:0] rdata_q;

  // Write port and read register; the read register holds when re is low.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/wb_memory_responder.sv
// Wishbone classic memory endpoint: wait-state counter, address decode,
// tag checking and a word-addressed RAM behind it.
module wb_memory_responder
  import wb_memory_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  wb_memory_responder_if.slave  wb
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic        we_q, we_d;
  logic        ack_q, ack_d;
  logic        rd_valid_q, rd_valid_d;
  logic        gnt_q, gnt_d;
  logic        mm_q, mm_d;

  logic                  req;
  logic                  op_we;
  logic [31:0]           addr_src;
  logic [31:0]           offset;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic                  ram_re;
  logic [31:0]           ram_rdata;

  // Decode the address of the transfer in flight; in IDLE that is the live
  // bus so a zero-wait read can still launch its RAM read a cycle before ACK.
  always_comb begin
    req      = wb.CYC_I & wb.STB_I;
    addr_src = (state_q == ST_IDLE) ? wb.ADR_I : adr_q;
    op_we    = (state_q == ST_IDLE) ? wb.WE_I  : we_q;
    offset   = addr_src - BASE_ADDR;
    in_range = (offset >> ADDR_WIDTH) == 32'd0;
    ram_addr = offset[ADDR_WIDTH-1:0];
  end

  // Next-state, counter, request latch and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    we_d       = we_q;
    mm_d       = mm_q;
    rd_valid_d = rd_valid_q;
    gnt_d      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          adr_d   = wb.ADR_I;
          we_d    = wb.WE_I;
          wdat_d  = wb.DAT_I;
          cnt_d   = WAIT_CNT;
          mm_d    = mm_q | (wb.WE_I != tag_is_write(wb.TGC_I));
          state_d = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = ST_ACK;
          end
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ack_d = (state_d == ST_ACK);
    // DAT_O follows the RAM only after an in-range read; out-of-range reads show zero.
    if (state_d == ST_ACK && !op_we) begin
      rd_valid_d = in_range;
    end
    ram_re = (state_d == ST_ACK) && !op_we && in_range && !RST_I;
    ram_we = (state_q == ST_ACK) && we_q && in_range && !RST_I;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      adr_q      <= 32'h0;
      wdat_q     <= 32'h0;
      we_q       <= 1'b0;
      ack_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      gnt_q      <= 1'b0;
      mm_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      adr_q      <= adr_d;
      wdat_q     <= wdat_d;
      we_q       <= we_d;
      ack_q      <= ack_d;
      rd_valid_q <= rd_valid_d;
      gnt_q      <= gnt_d;
      mm_q       <= mm_d;
    end
  end

  wb_responder_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (CLK_I),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (wdat_q),
    .rdata (ram_rdata)
  );

  assign wb.DAT_O        = rd_valid_q ? ram_rdata : 32'h0;
  assign wb.ACK_O        = ack_q;
  assign wb.GNT_O        = gnt_q;
  assign wb.oTagMismatch = mm_q;

endmodule

// File: tb/tb_wb_memory_responder.sv
// Bench for wb_memory_responder: three configurations sharing one stimulus bus.
module tb_wb_memory_responder;
  import wb_memory_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] adr = 32'h0;
  logic [31:0] dat = 32'h0;
  logic [1:0]  tgc = 2'd0;
  int          sel = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] model [int];

  always #5 clk = ~clk;

  wb_memory_responder_if if_a ();
  wb_memory_responder_if if_b ();
  wb_memory_responder_if if_c ();

  assign if_a.CYC_I = cyc && (sel == 0);
  assign if_b.CYC_I = cyc && (sel == 1);
  assign if_c.CYC_I = cyc && (sel == 2);
  assign if_a.STB_I = stb;
  assign if_b.STB_I = stb;
  assign if_c.STB_I = stb;
  assign if_a.WE_I  = we;
  assign if_b.WE_I  = we;
  assign if_c.WE_I  = we;
  assign if_a.ADR_I = adr;
  assign if_b.ADR_I = adr;
  assign if_c.ADR_I = adr;
  assign if_a.DAT_I = dat;
  assign if_b.DAT_I = dat;
  assign if_c.DAT_I = dat;
  assign if_a.TGC_I = tgc;
  assign if_b.TGC_I = tgc;
  assign if_c.TGC_I = tgc;

  wb_memory_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2), .BASE_ADDR(32'h0))
    u_a (.CLK_I(clk), .RST_I(rst), .wb(if_a));
  wb_memory_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0), .BASE_ADDR(32'h0))
    u_b (.CLK_I(clk), .RST_I(rst), .wb(if_b));
  wb_memory_responder #(.ADDR_WIDTH(4), .WAIT_STATES(1), .BASE_ADDR(32'h100))
    u_c (.CLK_I(clk), .RST_I(rst), .wb(if_c));

  function automatic int ws_of(input int d);
    case (d) 0: return 2; 1: return 0; default: return 1; endcase
  endfunction
  function automatic int aw_of(input int d);
    return (d == 2) ? 4 : 10;
  endfunction
  function automatic logic [31:0] base_of(input int d);
    return (d == 2) ? 32'h100 : 32'h0;
  endfunction
  function automatic bit in_rng(input int d, input logic [31:0] a);
    logic [31:0] off;
    off = a - base_of(d);
    return off < (32'd1 << aw_of(d));
  endfunction
  function automatic int key(input int d, input logic [31:0] a);
    return d * 4096 + int'(a - base_of(d));
  endfunction

  function automatic logic get_ack(input int d);
    case (d) 0: return if_a.ACK_O; 1: return if_b.ACK_O; default: return if_c.ACK_O; endcase
  endfunction
  function automatic logic [31:0] get_dat(input int d);
    case (d) 0: return if_a.DAT_O; 1: return if_b.DAT_O; default: return if_c.DAT_O; endcase
  endfunction
  function automatic logic get_gnt(input int d);
    case (d) 0: return if_a.GNT_O; 1: return if_b.GNT_O; default: return if_c.GNT_O; endcase
  endfunction
  function automatic logic get_mm(input int d);
    case (d) 0: return if_a.oTagMismatch; 1: return if_b.oTagMismatch; default: return if_c.oTagMismatch; endcase
  endfunction

  // One single transfer: returns ACK latency in cycles after sampling (-1 on timeout).
  task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] tg, output logic [31:0] rd, output int lat);
    @(negedge clk);
    sel = d; cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = wd; tgc = tg;
    lat = -1;
    rd  = 32'h0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (get_ack(d)) begin
        lat = i;
        rd  = get_dat(d);
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    if (lat > 0 && w && in_rng(d, a)) model[key(d, a)] = wd;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total++; if (get_ack(d) !== 1'b0) begin bad++; $display("FAIL reset_ack dut%0d got=%b want=0", d, get_ack(d)); end
      total++; if (get_dat(d) !== 32'h0) begin bad++; $display("FAIL reset_dat dut%0d got=%h want=0", d, get_dat(d)); end
      total++; if (get_gnt(d) !== 1'b0) begin bad++; $display("FAIL reset_gnt dut%0d got=%b want=0", d, get_gnt(d)); end
      total++; if (get_mm(d) !== 1'b0) begin bad++; $display("FAIL reset_mm dut%0d got=%b want=0", d, get_mm(d)); end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total++; if (get_gnt(d) !== 1'b1) begin bad++; $display("FAIL gnt_after_reset dut%0d got=%b want=1", d, get_gnt(d)); end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    int lat;
    xfer(0, 1'b1, 32'd5, 32'hDEADBEEF, WB_SIMPLE_WRITE_CYCLE, rd, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL wr_latency got=%0d want=3", lat); end
    xfer(0, 1'b0, 32'd5, 32'h0, WB_SIMPLE_READ_CYCLE, rd, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL rd_latency got=%0d want=3", lat); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h want=deadbeef", rd); end
  endtask

  // Preloads n words, then holds STB and walks the address on every ACK.
  task automatic test_burst(input int d, input logic [31:0] start, input int n);
    logic [31:0] rd;
    int lat, acks, last, consec;
    logic prev;
    for (int i = 0; i < n; i++) xfer(d, 1'b1, start + 32'(i), $urandom, WB_SIMPLE_WRITE_CYCLE, rd, lat);
    @(negedge clk);
    sel = d; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = start; tgc = WB_SIMPLE_READ_CYCLE;
    acks = 0; last = 0; consec = 0; prev = 1'b0;
    for (int c = 0; c < 200 && acks < n; c++) begin
      @(negedge clk);
      if (get_ack(d) && prev) consec++;
      prev = get_ack(d);
      if (get_ack(d)) begin
        if (acks > 0) begin
          total++; if (c - last !== ws_of(d) + 2) begin bad++; $display("FAIL burst_period dut%0d got=%0d want=%0d", d, c - last, ws_of(d) + 2); end
        end
        total++; if (get_dat(d) !== model[key(d, adr)]) begin bad++; $display("FAIL burst_data dut%0d adr=%0d got=%h want=%h", d, adr, get_dat(d), model[key(d, adr)]); end
        last = c;
        acks++;
        adr = adr + 32'd1;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    total++; if (acks !== n) begin bad++; $display("FAIL burst_acks dut%0d got=%0d want=%0d", d, acks, n); end
    total++; if (consec !== 0) begin bad++; $display("FAIL burst_ack_consecutive dut%0d got=%0d want=0", d, consec); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd;
    int lat;
    xfer(1, 1'b1, 32'd12, 32'h0BADF00D, WB_SIMPLE_WRITE_CYCLE, rd, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL zw_wr_latency got=%0d want=1", lat); end
    xfer(1, 1'b0, 32'd12, 32'h0, WB_SIMPLE_READ_CYCLE, rd, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL zw_rd_latency got=%0d want=1", lat); end
    total++; if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL zw_rd_data got=%h want=0badf00d", rd); end
    test_burst(1, 32'd40, 4);
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd;
    int lat;
    xfer(2, 1'b1, 32'h100, 32'hA5A50000, WB_SIMPLE_WRITE_CYCLE, rd, lat);
    xfer(2, 1'b1, 32'h110, 32'h1234, WB_SIMPLE_WRITE_CYCLE, rd, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL oor_wr_ack got=%0d want=2", lat); end
    xfer(2, 1'b0, 32'h100, 32'h0, WB_SIMPLE_READ_CYCLE, rd, lat);
    total++; if (rd !== 32'hA5A50000) begin bad++; $display("FAIL oor_word0_before got=%h want=a5a50000", rd); end
    xfer(2, 1'b0, 32'h110, 32'h0, WB_SIMPLE_READ_CYCLE, rd, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL oor_rd_ack got=%0d want=2", lat); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL oor_rd_data got=%h want=0", rd); end
    xfer(2, 1'b0, 32'h0FF, 32'h0, WB_SIMPLE_READ_CYCLE, rd, lat);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL below_base_rd got=%h want=0", rd); end
    xfer(2, 1'b0, 32'h100, 32'h0, WB_SIMPLE_READ_CYCLE, rd, lat);
    total++; if (rd !== 32'hA5A50000) begin bad++; $display("FAIL oor_word0_after got=%h want=a5a50000", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, a;
    int lat, d;
    bit w;
    for (int i = 0; i < 30; i++) begin
      d = $urandom_range(0, 1);
      w = $urandom_range(0, 1) == 1;
      a = 32'd64 + 32'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) a = 32'h400 + 32'($urandom_range(0, 255));
      xfer(d, w, a, $urandom, w ? WB_SIMPLE_WRITE_CYCLE : WB_SIMPLE_READ_CYCLE, rd, lat);
      total++; if (lat !== ws_of(d) + 1) begin bad++; $display("FAIL rand_latency dut%0d got=%0d want=%0d", d, lat, ws_of(d) + 1); end
      if (!w && !in_rng(d, a)) begin
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL rand_oor_rd dut%0d adr=%h got=%h want=0", d, a, rd); end
      end else if (!w && model.exists(key(d, a))) begin
        total++; if (rd !== model[key(d, a)]) begin bad++; $display("FAIL rand_rd dut%0d adr=%h got=%h want=%h", d, a, rd, model[key(d, a)]); end
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    int lat, acks;
    xfer(0, 1'b1, 32'd20, 32'h13572468, WB_SIMPLE_WRITE_CYCLE, rd, lat);
    @(negedge clk);
    sel = 0; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'd20; dat = 32'hFFFF0000; tgc = WB_SIMPLE_WRITE_CYCLE;
    @(negedge clk);
    acks = get_ack(0) ? 1 : 0;
    stb = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (get_ack(0)) acks++;
    end
    cyc = 1'b0;
    total++; if (acks !== 0) begin bad++; $display("FAIL abort_ack got=%0d want=0", acks); end
    xfer(0, 1'b0, 32'd20, 32'h0, WB_SIMPLE_READ_CYCLE, rd, lat);
    total++; if (rd !== 32'h13572468) begin bad++; $display("FAIL abort_no_write got=%h want=13572468", rd); end
  endtask

  task automatic test_tag_mismatch();
    logic [31:0] rd;
    int lat;
    total++; if (get_mm(0) !== 1'b0) begin bad++; $display("FAIL mm_initial got=%b want=0", get_mm(0)); end
    xfer(0, 1'b1, 32'd30, 32'hCAFE0030, WB_SIMPLE_READ_CYCLE, rd, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL mm_wr_latency got=%0d want=3", lat); end
    total++; if (get_mm(0) !== 1'b1) begin bad++; $display("FAIL mm_set got=%b want=1", get_mm(0)); end
    xfer(0, 1'b0, 32'd30, 32'h0, WB_SIMPLE_READ_CYCLE, rd, lat);
    total++; if (rd !== 32'hCAFE0030) begin bad++; $display("FAIL mm_write_done got=%h want=cafe0030", rd); end
    repeat (5) @(negedge clk);
    total++; if (get_mm(0) !== 1'b1) begin bad++; $display("FAIL mm_sticky got=%b want=1", get_mm(0)); end
    pulse_reset();
    total++; if (get_mm(0) !== 1'b0) begin bad++; $display("FAIL mm_cleared got=%b want=0", get_mm(0)); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd;
    int lat;
    bit seen;
    xfer(0, 1'b1, 32'd31, 32'h31313131, WB_SIMPLE_WRITE_CYCLE, rd, lat);
    xfer(0, 1'b0, 32'd30, 32'h0, WB_SIMPLE_READ_CYCLE, rd, lat);
    total++; if (get_dat(0) !== 32'hCAFE0030) begin bad++; $display("FAIL pre_reset_dat got=%h want=cafe0030", get_dat(0)); end
    @(negedge clk);
    sel = 0; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'd31; dat = 32'hEEEEEEEE; tgc = WB_SIMPLE_WRITE_CYCLE;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (get_ack(0)) begin
        seen = 1'b1;
        rst = 1'b1;
        break;
      end
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL rst_ack_seen got=%b want=1", seen); end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    total++; if (get_ack(0) !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b want=0", get_ack(0)); end
    total++; if (get_dat(0) !== 32'h0) begin bad++; $display("FAIL rst_dat got=%h want=0", get_dat(0)); end
    total++; if (get_gnt(0) !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%b want=0", get_gnt(0)); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (get_gnt(0) !== 1'b1) begin bad++; $display("FAIL rst_gnt_back got=%b want=1", get_gnt(0)); end
    xfer(0, 1'b0, 32'd31, 32'h0, WB_SIMPLE_READ_CYCLE, rd, lat);
    total++; if (rd !== 32'h31313131) begin bad++; $display("FAIL rst_no_write got=%h want=31313131", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_burst(0, 32'd8, 3);
    test_zero_wait();
    test_out_of_range();
    test_random();
    test_abort();
    test_tag_mismatch();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
